fft_input_loader: RTL and testbench
===================================

# fft_input_loader

Input-side loader for the sequential FFT core. It accepts a stream of complex samples over a valid/ready handshake and writes each frame of N samples into the FFT working RAM at bit-reversed addresses. When the frame is complete it pulses `flag_start_FFT` to the FFT control FSM, then holds off further input until that FSM returns `done_o`. It is the writer at the opposite end of the RAM from the FFT read controller.

## Interface
- `bit_width`, 29, width of each real/imag sample component
- `N`, 16, FFT points per frame; equals 2**SIZE
- `SIZE`, 4, log2(N)

- `clk` in 1 — single clock; all logic on the rising edge
- `rst` in 1 — asynchronous, active-high reset
- `in_valid` in 1 — sample present on `in_re`/`in_im`
- `in_re` in bit_width — real part
- `in_im` in bit_width — imaginary part
- `in_ready` out 1 — loader accepts a sample this cycle
- `wr_en` out 1 — RAM write strobe
- `wr_ptr` out SIZE+1 — RAM write address; MSB always 0
- `wr_re` out bit_width — RAM write data, real part
- `wr_im` out bit_width — RAM write data, imaginary part
- `flag_start_FFT` out 1 — one-cycle start pulse to the FFT controller
- `done_o` in 1 — FFT controller has finished output for the frame
- `busy` out 1 — a frame is handed off and the FFT is running
- `drop_cnt` out 8 — dropped-beat counter (see Configuration)

## Operation
- **Accept rule:** a beat is accepted when `in_valid && in_ready`. `in_ready = (state == LOAD)` and is decoded from registered state.
- **Sample count:** a SIZE-bit counter `cnt` is cleared in reset and on entry to LOAD. It increments once per accepted beat.
- **Write pipeline:** every accepted beat is registered for one cycle. Next cycle: `wr_en = 1`, `wr_ptr = {1'b0, bitrev(cnt)}`, `wr_re/wr_im` = the captured data. `bitrev` reverses all SIZE bits, so for N=16, index 1 maps to 8 and index 3 maps to 12.
- **FSM states:**
  - LOAD: accept beats. On the beat with `cnt == N-1`, go to START.
  - START: `wr_en` is asserted for the last sample. Go to PULSE.
  - PULSE: `flag_start_FFT = 1` for exactly this cycle. Go to BUSY.
  - BUSY: `busy = 1` and `in_ready = 0`. When `done_o = 1`, go to LOAD and clear `cnt`.
- **Ignored `done_o`:** `done_o` is ignored in LOAD, START and PULSE.
- **Arithmetic:**
  - `cnt` wraps naturally at N. No write is ever issued with `cnt >= N`.
  - Data passes through unmodified: no scaling, no sign extension.
- **Reset mid-frame:** the partial frame is discarded. The state returns to LOAD with `cnt = 0`. Any pending write is cancelled (`wr_en` forced to 0). RAM contents are not cleared.
- **Back-to-back input:** full rate is supported in LOAD, i.e. N accepted beats in N consecutive cycles.

## Timing
- **Reset values:**
  - `in_ready = 1` (state LOAD)
  - `wr_en = 0`, `wr_ptr = 0`, `wr_re = 0`, `wr_im = 0`
  - `flag_start_FFT = 0`, `busy = 0`, `drop_cnt = 0`
- **Write latency:** beat accepted at cycle t → write visible on the RAM port at cycle t+1.
- **Last beat of a frame at cycle t:**
  - t+1: `in_ready = 0`, last write issued.
  - t+2: `flag_start_FFT = 1`.
  - t+3: `busy = 1`.
- The start pulse is guaranteed to come after the final RAM write has been presented.
- **`done_o` sampled high at cycle d in BUSY:** `busy = 0` and `in_ready = 1` at d+1. The earliest new accept is at d+1.
- **Pulse spacing:** minimum N+2 cycles between `flag_start_FFT` pulses, plus FFT run time.

## Configuration
- **Macro:** `FFT_LOADER_DROP_CNT_EN`.
- **Defined:** `drop_cnt` counts cycles with `in_valid && !in_ready`. It is 8 bits, saturates at 255, and is cleared only by reset.
- **Undefined:** `drop_cnt` is tied to 0 and no counter logic is synthesized. The port is present in both builds.

## Test plan
- **Frame load:** N=16, feed samples with `in_re = 0..15` on consecutive cycles → writes go to addresses 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 with matching data. `flag_start_FFT` pulses exactly 2 cycles after the 16th accept.
- **Backpressure:** in BUSY, hold `in_valid = 1` for 20 cycles → `in_ready = 0` and no `wr_en` throughout. Assert `done_o` → `in_ready = 1` next cycle, and the next beat is written to address 0.
- **Gapped input:** insert random idle cycles in `in_valid` → still exactly 16 writes and one pulse per frame, with the bit-reversed order preserved.
- **Reset mid-frame:** assert `rst` after 7 accepts → all outputs return to reset values, `cnt = 0`. The next 16 accepts form a full frame and pulse once.
- **Spurious `done_o`:** pulse `done_o` during LOAD after 3 accepts → no state change. The frame completes normally after 13 more accepts.
- **Drop counter (macro defined):** hold `in_valid` high for 300 cycles in BUSY → `drop_cnt = 255`. Macro undefined: `drop_cnt = 0`.

Source files
------------

// File: rtl/fft_input_loader.sv
// Input-side loader for the sequential FFT core: streams N complex samples into the
// working RAM at bit-reversed addresses, then starts the FFT and waits for done_o.
// Optional build macro FFT_LOADER_DROP_CNT_EN enables the saturating drop_cnt counter.
module fft_input_loader #(
  parameter int bit_width = 29,
  parameter int N         = 16,
  parameter int SIZE      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [bit_width-1:0] in_re,
  input  logic [bit_width-1:0] in_im,
  output logic                 in_ready,
  output logic                 wr_en,
  output logic [SIZE:0]        wr_ptr,
  output logic [bit_width-1:0] wr_re,
  output logic [bit_width-1:0] wr_im,
  output logic                 flag_start_FFT,
  input  logic                 done_o,
  output logic                 busy,
  output logic [7:0]           drop_cnt
);

  typedef enum logic [1:0] {LOAD, START, PULSE, BUSY} state_t;

  state_t          state;
  logic [SIZE-1:0] cnt;
  logic [SIZE-1:0] cnt_rev;
  logic [1:0]      vld_pipe;

  assign in_ready    = (state == LOAD);
  assign vld_pipe[0] = in_valid && in_ready;
  assign wr_en       = vld_pipe[1];

  for (genvar i = 0; i < SIZE; i++) begin : g_rev
    assign cnt_rev[i] = cnt[SIZE-1-i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= LOAD;
      cnt            <= '0;
      vld_pipe[1]    <= 1'b0;
      wr_ptr         <= '0;
      wr_re          <= '0;
      wr_im          <= '0;
      flag_start_FFT <= 1'b0;
      busy           <= 1'b0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      if (vld_pipe[0]) begin
        wr_ptr <= {1'b0, cnt_rev};
        wr_re  <= in_re;
        wr_im  <= in_im;
        cnt    <= cnt + 1'b1;
      end
      // Pulse and busy are registered one state ahead so they line up with state.
      flag_start_FFT <= (state == START);
      busy           <= (state == PULSE) || (state == BUSY && !done_o);
      case (state)
        LOAD:  if (vld_pipe[0] && cnt == SIZE'(N-1)) state <= START;
        START: state <= PULSE;
        PULSE: state <= BUSY;
        BUSY: if (done_o) begin
          state <= LOAD;
          cnt   <= '0;
        end
        default: state <= LOAD;
      endcase
    end
  end

`ifdef FFT_LOADER_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      drop_cnt <= '0;
    else if (in_valid && !in_ready && drop_cnt != 8'hFF)
      drop_cnt <= drop_cnt + 8'd1;
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed bench for fft_input_loader: a vector table for the first frame, then
// hand-written sequences for backpressure, reset mid-frame, gaps, spurious done_o, drops.
module tb_fft_input_loader;
  localparam int BW = 29;
  localparam logic [4:0] ADDR [16] = '{5'd0, 5'd8, 5'd4, 5'd12, 5'd2, 5'd10, 5'd6, 5'd14,
                                       5'd1, 5'd9, 5'd5, 5'd13, 5'd3, 5'd11, 5'd7, 5'd15};
  localparam logic [BW-1:0] IM0 = 29'h1FFF_FFF0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [BW-1:0] in_re = '0, in_im = '0;
  logic          in_ready, wr_en, flag_start_FFT, busy;
  logic          done_o = 1'b0;
  logic [4:0]    wr_ptr;
  logic [BW-1:0] wr_re, wr_im;
  logic [7:0]    drop_cnt;

  fft_input_loader #(.bit_width(BW), .N(16), .SIZE(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
    .in_ready(in_ready), .wr_en(wr_en), .wr_ptr(wr_ptr), .wr_re(wr_re), .wr_im(wr_im),
    .flag_start_FFT(flag_start_FFT), .done_o(done_o), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [BW-1:0] re, im;
    logic          done;
    logic          e_rdy, e_wen;
    logic [4:0]    e_ptr;
    logic [BW-1:0] e_re, e_im;
    logic          e_flag, e_busy;
  } vec_t;

  vec_t          tbl [19];
  int            n_vec = 0, n_bad = 0, pulses = 0;
  logic [4:0]    wq_ptr [$];
  logic [BW-1:0] wq_re [$], wq_im [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: drive after a falling edge, return at the next falling edge.
  task automatic cyc(input logic v, input logic [BW-1:0] re, input logic [BW-1:0] im,
                     input logic d);
    in_valid = v; in_re = re; in_im = im; done_o = d;
    @(negedge clk);
    if (wr_en) begin
      wq_ptr.push_back(wr_ptr); wq_re.push_back(wr_re); wq_im.push_back(wr_im);
    end
    if (flag_start_FFT) pulses++;
  endtask

  task automatic clear_log();
    wq_ptr.delete(); wq_re.delete(); wq_im.delete(); pulses = 0;
  endtask

  task automatic verify_frame(input string nm, input logic [BW-1:0] base);
    chk({nm, " writes"}, 64'(wq_ptr.size()), 64'd16);
    chk({nm, " pulses"}, 64'(pulses), 64'd1);
    if (wq_ptr.size() == 16)
      for (int k = 0; k < 16; k++) begin
        chk($sformatf("%s ptr[%0d]", nm, k), 64'(wq_ptr[k]), 64'(ADDR[k]));
        chk($sformatf("%s re[%0d]", nm, k), 64'(wq_re[k]), 64'(base + BW'(k)));
        chk($sformatf("%s im[%0d]", nm, k), 64'(wq_im[k]), 64'(IM0 + BW'(k)));
      end
    clear_log();
  endtask

  task automatic feed(input logic [BW-1:0] base, input bit gaps);
    for (int k = 0; k < 16; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) cyc(1'b0, '0, '0, 1'b0);
      cyc(1'b1, base + BW'(k), IM0 + BW'(k), 1'b0);
    end
    cyc(1'b0, '0, '0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin
      tbl[k].v = 1'b1; tbl[k].re = BW'(k); tbl[k].im = IM0 + BW'(k); tbl[k].done = 1'b0;
      tbl[k].e_rdy = (k != 15); tbl[k].e_wen = 1'b1; tbl[k].e_ptr = ADDR[k];
      tbl[k].e_re = BW'(k); tbl[k].e_im = IM0 + BW'(k);
      tbl[k].e_flag = 1'b0; tbl[k].e_busy = 1'b0;
    end
    for (int k = 16; k < 19; k++) begin
      tbl[k].v = (k == 18); tbl[k].re = '0; tbl[k].im = '0; tbl[k].done = 1'b0;
      tbl[k].e_rdy = 1'b0; tbl[k].e_wen = 1'b0; tbl[k].e_ptr = '0;
      tbl[k].e_re = '0; tbl[k].e_im = '0;
      tbl[k].e_flag = (k == 16); tbl[k].e_busy = (k != 16);
    end

    // Reset values
    #12;
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst wr_en", 64'(wr_en), 64'd0);
    chk("rst wr_ptr", 64'(wr_ptr), 64'd0);
    chk("rst wr_re", 64'(wr_re), 64'd0);
    chk("rst wr_im", 64'(wr_im), 64'd0);
    chk("rst flag", 64'(flag_start_FFT), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst drop_cnt", 64'(drop_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // First frame, cycle-exact, ending in BUSY with input held valid
    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].v, tbl[i].re, tbl[i].im, tbl[i].done);
      chk($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(tbl[i].e_rdy));
      chk($sformatf("v%0d wr_en", i), 64'(wr_en), 64'(tbl[i].e_wen));
      chk($sformatf("v%0d flag", i), 64'(flag_start_FFT), 64'(tbl[i].e_flag));
      chk($sformatf("v%0d busy", i), 64'(busy), 64'(tbl[i].e_busy));
      if (tbl[i].e_wen) begin
        chk($sformatf("v%0d wr_ptr", i), 64'(wr_ptr), 64'(tbl[i].e_ptr));
        chk($sformatf("v%0d wr_re", i), 64'(wr_re), 64'(tbl[i].e_re));
        chk($sformatf("v%0d wr_im", i), 64'(wr_im), 64'(tbl[i].e_im));
      end
    end
    chk("frame0 pulses", 64'(pulses), 64'd1);
    clear_log();

    // Backpressure in BUSY
    repeat (20) begin
      cyc(1'b1, 29'h7, 29'h7, 1'b0);
      chk("bp in_ready", 64'(in_ready), 64'd0);
      chk("bp busy", 64'(busy), 64'd1);
    end
    chk("bp writes", 64'(wq_ptr.size()), 64'd0);
    cyc(1'b0, '0, '0, 1'b1);
    chk("done in_ready", 64'(in_ready), 64'd1);
    chk("done busy", 64'(busy), 64'd0);
    cyc(1'b1, 29'h55, 29'h66, 1'b0);
    chk("post-done wr_en", 64'(wr_en), 64'd1);
    chk("post-done wr_ptr", 64'(wr_ptr), 64'd0);
    chk("post-done wr_re", 64'(wr_re), 64'h55);

    // Reset after 7 accepts, with a write pending on the port
    for (int k = 1; k < 7; k++) cyc(1'b1, BW'(k), BW'(k), 1'b0);
    chk("pre-rst wr_en", 64'(wr_en), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst wr_en", 64'(wr_en), 64'd0);
    chk("midrst wr_ptr", 64'(wr_ptr), 64'd0);
    chk("midrst wr_re", 64'(wr_re), 64'd0);
    chk("midrst in_ready", 64'(in_ready), 64'd1);
    chk("midrst busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_log();

    // Gapped frame after reset must start again at index 0
    feed(29'h100, 1'b1);
    chk("gap busy", 64'(busy), 64'd1);
    verify_frame("gap", 29'h100);
    cyc(1'b0, '0, '0, 1'b1);

    // Spurious done_o during LOAD after 3 accepts
    for (int k = 0; k < 16; k++) begin
      if (k == 3) begin
        cyc(1'b0, '0, '0, 1'b1);
        chk("spur in_ready", 64'(in_ready), 64'd1);
        chk("spur busy", 64'(busy), 64'd0);
      end
      cyc(1'b1, 29'h200 + BW'(k), IM0 + BW'(k), k == 3);
    end
    cyc(1'b0, '0, '0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0);
    verify_frame("spur", 29'h200);

    // Drop counter saturation in BUSY
    repeat (300) cyc(1'b1, 29'h9, 29'h9, 1'b0);
`ifdef FFT_LOADER_DROP_CNT_EN
    chk("drop_cnt sat", 64'(drop_cnt), 64'd255);
`else
    chk("drop_cnt off", 64'(drop_cnt), 64'd0);
`endif
    chk("drop busy", 64'(busy), 64'd1);
    chk("drop writes", 64'(wq_ptr.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
